// File: rtl/gen_data_reg.sv
// Parametrised datapath register: load, step increment/decrement (wrap or saturate),
// serial shifts, registered carry/borrow/shift-out, zero flag and sticky overflow.
module gen_data_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] STEP      = 1,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             LD,
    input  logic             INC,
    input  logic             DEC,
    input  logic             SHL,
    input  logic             SHR,
    input  logic             SIN,
    input  logic             OVF_CLR,
    input  logic [WIDTH-1:0] D_IN,
    output logic [WIDTH-1:0] Q,
    output logic             COUT,
    output logic             ZERO,
    output logic             OVF
);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] shl_val, shr_val;

    // The extra MSB of each extended result is the carry (sum) or borrow (difference).
    assign sum_ext  = {1'b0, q_reg} + {1'b0, STEP};
    assign diff_ext = {1'b0, q_reg} - {1'b0, STEP};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl_val[gi] = SIN;
            end else begin : g_mid_l
                assign shl_val[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign shr_val[gi] = SIN;
            end else begin : g_mid_r
                assign shr_val[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        q_next    = q_reg;
        cout_next = cout_reg;
        ovf_next  = ovf_reg & ~OVF_CLR;
        if (CLR) begin
            q_next    = '0;
            cout_next = 1'b0;
        end else if (LD) begin
            q_next    = D_IN;
            cout_next = 1'b0;
        end else if (INC && DEC) begin
            // Opposing steps cancel: nothing moves and shifts are suppressed.
            q_next    = q_reg;
        end else if (INC) begin
            cout_next = sum_ext[WIDTH];
            if (sum_ext[WIDTH]) begin
                ovf_next = 1'b1;
                q_next   = SATURATE ? '1 : sum_ext[WIDTH-1:0];
            end else begin
                q_next   = sum_ext[WIDTH-1:0];
            end
        end else if (DEC) begin
            cout_next = diff_ext[WIDTH];
            if (diff_ext[WIDTH]) begin
                ovf_next = 1'b1;
                q_next   = SATURATE ? '0 : diff_ext[WIDTH-1:0];
            end else begin
                q_next   = diff_ext[WIDTH-1:0];
            end
        end else if (SHL) begin
            q_next    = shl_val;
            cout_next = q_reg[WIDTH-1];
        end else if (SHR) begin
            q_next    = shr_val;
            cout_next = q_reg[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_reg    <= RESET_VAL;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            cout_reg <= cout_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign Q    = q_reg;
    assign COUT = cout_reg;
    assign OVF  = ovf_reg;
    assign ZERO = (q_reg == '0);

endmodule

// File: tb/tb_gen_data_reg.sv
// Scoreboard bench: five differently parametrised registers share one stimulus stream;
// an arithmetic reference model queues expectations that a monitor pops every cycle.
module tb_gen_data_reg;

    localparam int NDUT = 5;
    localparam int unsigned P_W   [NDUT] = '{16, 16, 16, 4, 16};
    localparam int unsigned P_STEP[NDUT] = '{1, 1, 4, 3, 1};
    localparam bit          P_SAT [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam int unsigned P_RV  [NDUT] = '{0, 32'h00FF, 0, 0, 0};

    logic CLK, RST_N, CLR, LD, INC, DEC, SHL, SHR, SIN, OVF_CLR;
    logic [15:0] D_IN;

    logic [15:0] q0, q1, q2, q4;
    logic [3:0]  q3;
    logic [NDUT-1:0] cout_v, zero_v, ovf_v;
    logic [15:0] q_arr [NDUT];

    assign q_arr[0] = q0;
    assign q_arr[1] = q1;
    assign q_arr[2] = q2;
    assign q_arr[3] = {12'd0, q3};
    assign q_arr[4] = q4;

    gen_data_reg #(.WIDTH(16), .STEP(16'd1), .SATURATE(1'b0), .RESET_VAL(16'h0000)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
        .SIN(SIN), .OVF_CLR(OVF_CLR), .D_IN(D_IN), .Q(q0), .COUT(cout_v[0]), .ZERO(zero_v[0]), .OVF(ovf_v[0]));
    gen_data_reg #(.WIDTH(16), .STEP(16'd1), .SATURATE(1'b0), .RESET_VAL(16'h00FF)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
        .SIN(SIN), .OVF_CLR(OVF_CLR), .D_IN(D_IN), .Q(q1), .COUT(cout_v[1]), .ZERO(zero_v[1]), .OVF(ovf_v[1]));
    gen_data_reg #(.WIDTH(16), .STEP(16'd4), .SATURATE(1'b1), .RESET_VAL(16'h0000)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
        .SIN(SIN), .OVF_CLR(OVF_CLR), .D_IN(D_IN), .Q(q2), .COUT(cout_v[2]), .ZERO(zero_v[2]), .OVF(ovf_v[2]));
    gen_data_reg #(.WIDTH(4), .STEP(4'd3), .SATURATE(1'b0), .RESET_VAL(4'h0)) u_dut3 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
        .SIN(SIN), .OVF_CLR(OVF_CLR), .D_IN(D_IN[3:0]), .Q(q3), .COUT(cout_v[3]), .ZERO(zero_v[3]), .OVF(ovf_v[3]));
    gen_data_reg #(.WIDTH(16), .STEP(16'd1), .SATURATE(1'b1), .RESET_VAL(16'h0000)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LD(LD), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
        .SIN(SIN), .OVF_CLR(OVF_CLR), .D_IN(D_IN), .Q(q4), .COUT(cout_v[4]), .ZERO(zero_v[4]), .OVF(ovf_v[4]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [NDUT-1:0][15:0] q;
        logic [NDUT-1:0]       c;
        logic [NDUT-1:0]       o;
    } exp_t;

    exp_t  exp_q [$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;
    int    txn    = 0;

    // Reference state per DUT, held as plain integers.
    int unsigned m_q [NDUT];
    bit          m_c [NDUT];
    bit          m_o [NDUT];

    task automatic check(input string what, input int idx, input logic [15:0] act, input logic [15:0] expv,
                         input string nm);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d %s: got %h expected %h", nm, idx, what, act, expv);
        end
    endtask

    // Monitor: every cycle the DUTs present a new state, pop and compare.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                txn++;
                for (int i = 0; i < NDUT; i++) begin
                    check("Q",    i, q_arr[i],              e.q[i],                nm);
                    check("COUT", i, {15'd0, cout_v[i]},    {15'd0, e.c[i]},       nm);
                    check("OVF",  i, {15'd0, ovf_v[i]},     {15'd0, e.o[i]},       nm);
                    check("ZERO", i, {15'd0, zero_v[i]},    {15'd0, e.q[i] == 16'd0}, nm);
                end
                $display("txn %0d %-12s q0=%h c0=%b o0=%b q2=%h q3=%h q4=%h", txn, nm,
                         q0, cout_v[0], ovf_v[0], q2, q3, q4);
            end
        end
    end

    task automatic drive(input bit rstn, input bit clr, input bit ld, input bit inc, input bit dec,
                         input bit shl, input bit shr, input bit sin, input bit oclr,
                         input logic [15:0] din, input string nm);
        exp_t e;
        @(negedge CLK);
        RST_N = rstn; CLR = clr; LD = ld; INC = inc; DEC = dec;
        SHL = shl; SHR = shr; SIN = sin; OVF_CLR = oclr; D_IN = din;
        for (int i = 0; i < NDUT; i++) begin
            int unsigned mx  = (32'd1 << P_W[i]) - 1;
            int unsigned stp = P_STEP[i];
            bit          set = 1'b0;
            if (!rstn) begin
                m_q[i] = P_RV[i] & mx;
                m_c[i] = 1'b0;
                m_o[i] = 1'b0;
            end else begin
                if (clr) begin
                    m_q[i] = 0; m_c[i] = 1'b0;
                end else if (ld) begin
                    m_q[i] = din & mx; m_c[i] = 1'b0;
                end else if (inc && dec) begin
                    // net zero: nothing changes
                end else if (inc) begin
                    set = (m_q[i] + stp) > mx;
                    m_c[i] = set;
                    if (set) m_q[i] = P_SAT[i] ? mx : m_q[i] + stp - (mx + 1);
                    else     m_q[i] = m_q[i] + stp;
                end else if (dec) begin
                    set = m_q[i] < stp;
                    m_c[i] = set;
                    if (set) m_q[i] = P_SAT[i] ? 0 : m_q[i] + (mx + 1) - stp;
                    else     m_q[i] = m_q[i] - stp;
                end else if (shl) begin
                    m_c[i] = ((m_q[i] >> (P_W[i] - 1)) & 1) != 0;
                    m_q[i] = ((m_q[i] * 2) + sin) & mx;
                end else if (shr) begin
                    m_c[i] = (m_q[i] & 1) != 0;
                    m_q[i] = (m_q[i] / 2) + (sin ? (mx + 1) / 2 : 0);
                end
                m_o[i] = set | (m_o[i] & !oclr);
            end
            e.q[i] = m_q[i][15:0];
            e.c[i] = m_c[i];
            e.o[i] = m_o[i];
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        logic [15:0] din_r;
        RST_N = 1'b0; CLR = 1'b0; LD = 1'b0; INC = 1'b0; DEC = 1'b0;
        SHL = 1'b0; SHR = 1'b0; SIN = 1'b0; OVF_CLR = 1'b0; D_IN = '0;

        //           rstn clr ld inc dec shl shr sin oclr din
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 16'hBEEF, "reset_ld");
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 16'hBEEF, "reset_ld2");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFE, "ld_fffe");
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, "inc_held");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0, "ovf_clr");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF, "ld_ffff");
        drive(1, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0, "inc_ovfclr");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0006, "ld_0006");
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, "dec");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFD, "ld_fffd");
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, "inc_sat");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h8001, "ld_8001");
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0, "shl_sin0");
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0, "shr_sin1");
        drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 16'h5555, "clr_ld_inc");
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 16'h1234, "ld_inc");
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0, "inc_dec");
        drive(1, 0, 0, 1, 0, 1, 0, 1, 0, 16'h0, "inc_shl");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h000E, "ld_000e");
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, "inc_w4");
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, "dec_w4");
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, "dec_w4b");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, "clr");
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, "dec_at_0");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, "reset_mid");

        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 4))
                0: din_r = 16'h0000;
                1: din_r = 16'hFFFF;
                2: din_r = 16'hFFFE;
                3: din_r = 16'h0001;
                default: din_r = 16'($urandom);
            endcase
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 7) == 0, din_r, "random");
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, "idle");
        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
